aidan_mcnay_prime_ctrl: RTL
===========================

# aidan_mcnay_prime_ctrl

Trial-division scheduler for primality testing of `nbits`-bit integers. It accepts one candidate over a val/rdy request stream and sequences the shared remainder divider (`opa mod opb`, val/rdy on both sides) through candidate divisors 2, 3, 5, 7, … until a zero remainder or `d*d > n`. It returns a prime/composite verdict plus the smallest factor found. It sits between the top-level request interface and the divider instance.

## Interface
- `nbits`, 16, width of the candidate, the divider operands and `resp_factor`
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_num`  in  nbits  candidate n
- `req_val` in 1, `req_rdy` out 1: request handshake
- `resp_is_prime`  out  1  1 means n is prime
- `resp_factor`  out  nbits  smallest factor if composite, else 0
- `resp_val` out 1, `resp_rdy` in 1: response handshake
- `div_opa`, `div_opb`  out  nbits  divider operands (n, d)
- `div_istream_val` out 1, `div_istream_rdy` in 1: divider issue handshake
- `div_result`  in  nbits  remainder n mod d
- `div_ostream_val` in 1, `div_ostream_rdy` out 1: divider result handshake

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, DONE.
- **IDLE**
  - `req_rdy=1`.
  - On `req_val`, capture n into `n_reg`, set d=2, and go to CHECK.
- **CHECK** (1 cycle)
  - n<2: verdict composite, factor 0, go to DONE.
  - n==2 or n==3: verdict prime, go to DONE.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Drive `div_istream_val=1`, `div_opa=n_reg`, `div_opb=d`.
  - On `div_istream_rdy`, go to WAIT.
  - Operands are held stable while stalled.
- **WAIT**
  - `div_ostream_rdy=1`. On `div_ostream_val`:
    - `div_result==0`: verdict composite, factor=d, go to DONE.
    - Otherwise d_next = 3 if d==2, else d+2.
    - If d_next*d_next > n_reg: verdict prime, go to DONE. Else d=d_next, go to ISSUE.
- **DONE**
  - `resp_val=1`.
  - `resp_is_prime` and `resp_factor` are held stable.
  - On `resp_rdy`, go to IDLE.
- Arithmetic rules:
  - The square compare uses 2*nbits-bit arithmetic and never overflows.
  - d never exceeds 2^(nbits/2); for n=16 the maximum issued d is 255.
- `div_opa` and `div_opb` are don't-care outside ISSUE. `div_istream_val=0` outside ISSUE.
- `div_ostream_rdy=1` in IDLE as well as WAIT, so a stale divider result left after reset is drained and discarded.
- Only one divider transaction is ever outstanding.

## Timing
- `reset_n` low forces IDLE immediately. During reset and after release:
  - `req_rdy=1`
  - `resp_val=0`, `resp_is_prime=0`, `resp_factor=0`
  - `div_istream_val=0`, `div_ostream_rdy=1`
- Reset mid-operation abandons the test. No response is produced.
- Trivial n: the request is accepted at cycle 0, CHECK at 1, `resp_val` at 2.
- Non-trivial n: 1 cycle (CHECK) plus, per divisor, at least 1 ISSUE cycle plus divider latency, then DONE.
- `resp_val` falls the cycle after the `resp_val && resp_rdy` handshake. The next request can be accepted that same following cycle (IDLE).
- `req_val` is ignored outside IDLE.
- All outputs are driven from registered state and registers; there is no combinational path from `req_val`/`resp_rdy`/divider inputs to outputs except the documented `*_rdy`/`*_val` state decodes.

## Structure
- Shared package/header `aidan_mcnay_prime_defs`:
  - state encodings (3-bit localparams)
  - default `nbits`
- Sub-module `aidan_mcnay_divisor_gen`:
  - holds d and d², with controls load (d=2, sq=4) and step (2→3, then +2)
  - updates the square incrementally (sq += 4d+4; +5 for the 2→3 step)
  - outputs `d` and the `sq_next > n` comparison
- The controller instantiates it. The divider is instantiated one level up, not inside the controller.

## Test plan
- n=0, n=1 → `resp_is_prime=0`, `resp_factor=0`, no divider transactions. n=2 and n=3 → prime, no divider transactions.
- n=97 → exactly 5 divider issues with d=2,3,5,7,9, then prime, factor 0. n=91 → issues d=2,3,5,7, then composite, factor 7.
- n=65521 → 128 issues, last d=255, prime. n=65535 → composite, factor 3 after 2 issues.
- Random `div_istream_rdy` and `div_ostream_val` stalls (behavioural divider with 1–20 cycle latency) → operands stable during stalls and verdicts match a reference model over 1000 random n.
- `resp_rdy` held low 10 cycles in DONE → `resp_*` stable, `req_rdy=0`. Release → IDLE on the next cycle and back-to-back requests accepted.
- `reset_n` pulsed low mid-WAIT while the divider holds a pending result → no `resp_val`, stale result drained in IDLE, next request n=91 returns factor 7.

Source files
------------

// File: rtl/aidan_mcnay_prime_defs.sv
// aidan_mcnay_prime_defs: shared state encodings and default width for the prime controller
package aidan_mcnay_prime_defs;
   localparam int NBITS = 16;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CHECK = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/aidan_mcnay_prime_ctrl_if.sv
// aidan_mcnay_prime_ctrl_if: request/response and divider streams of the prime controller
interface aidan_mcnay_prime_ctrl_if
   import aidan_mcnay_prime_defs::*;
#(parameter int nbits = NBITS) ();
   logic [nbits-1:0] req_num;
   logic             req_val;
   logic             req_rdy;
   logic             resp_is_prime;
   logic [nbits-1:0] resp_factor;
   logic             resp_val;
   logic             resp_rdy;
   logic [nbits-1:0] div_opa;
   logic [nbits-1:0] div_opb;
   logic             div_istream_val;
   logic             div_istream_rdy;
   logic [nbits-1:0] div_result;
   logic             div_ostream_val;
   logic             div_ostream_rdy;
   modport slave (
      input  req_num, req_val, resp_rdy, div_istream_rdy, div_result, div_ostream_val,
      output req_rdy, resp_is_prime, resp_factor, resp_val, div_opa, div_opb,
             div_istream_val, div_ostream_rdy
   );
   modport master (
      output req_num, req_val, resp_rdy, div_istream_rdy, div_result, div_ostream_val,
      input  req_rdy, resp_is_prime, resp_factor, resp_val, div_opa, div_opb,
             div_istream_val, div_ostream_rdy
   );
endinterface

// File: rtl/aidan_mcnay_divisor_gen.sv
// aidan_mcnay_divisor_gen: trial divisor sequence 2,3,5,7,... with an incrementally tracked square
module aidan_mcnay_divisor_gen
   import aidan_mcnay_prime_defs::*;
#(parameter int nbits = NBITS) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             step,
   input  logic [nbits-1:0] n,
   output logic [nbits-1:0] d,
   output logic             sq_gt
);
   logic [2*nbits-1:0] sq, sq_next;
   logic [nbits-1:0]   d_next;
   logic               d_is_two;
   assign d_is_two = d == nbits'(2);
   assign d_next   = d_is_two ? nbits'(3) : d + nbits'(2);
   // (d+2)^2 - d^2 = 4d+4; the 2->3 step adds 5
   assign sq_next  = sq + (d_is_two ? (2*nbits)'(5) : ((2*nbits)'(d) << 2) + (2*nbits)'(4));
   assign sq_gt    = sq_next > (2*nbits)'(n);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d  <= nbits'(2);
         sq <= (2*nbits)'(4);
      end else if (load) begin
         d  <= nbits'(2);
         sq <= (2*nbits)'(4);
      end else if (step) begin
         d  <= d_next;
         sq <= sq_next;
      end
   end
endmodule

// File: rtl/aidan_mcnay_prime_ctrl.sv
// aidan_mcnay_prime_ctrl: trial-division primality scheduler driving an external remainder divider
module aidan_mcnay_prime_ctrl
   import aidan_mcnay_prime_defs::*;
#(parameter int nbits = NBITS) (
   input  logic                    clk,
   input  logic                    reset_n,
   aidan_mcnay_prime_ctrl_if.slave io
);
   logic [2:0]       state, state_next;
   logic [nbits-1:0] n_reg, factor, d;
   logic             is_prime, sq_gt, got_res, rem_zero, load, step;
   assign got_res  = state == ST_WAIT && io.div_ostream_val;
   assign rem_zero = io.div_result == '0;
   assign load     = state == ST_IDLE && io.req_val;
   assign step     = got_res && !rem_zero && !sq_gt;
   aidan_mcnay_divisor_gen #(.nbits(nbits)) u_gen (
      .clk(clk), .reset_n(reset_n), .load(load), .step(step),
      .n(n_reg), .d(d), .sq_gt(sq_gt)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else state <= state_next;
   end
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  state_next = io.req_val ? ST_CHECK : ST_IDLE;
         ST_CHECK: state_next = n_reg < nbits'(4) ? ST_DONE : ST_ISSUE;
         ST_ISSUE: state_next = io.div_istream_rdy ? ST_WAIT : ST_ISSUE;
         ST_WAIT:  state_next = !got_res ? ST_WAIT : (rem_zero || sq_gt) ? ST_DONE : ST_ISSUE;
         ST_DONE:  state_next = io.resp_rdy ? ST_IDLE : ST_DONE;
         default:  state_next = ST_IDLE;
      endcase
   end
   always_comb begin
      io.req_rdy         = state == ST_IDLE;
      io.resp_val        = state == ST_DONE;
      io.resp_is_prime   = is_prime;
      io.resp_factor     = factor;
      io.div_istream_val = state == ST_ISSUE;
      io.div_ostream_rdy = state == ST_IDLE || state == ST_WAIT;
      io.div_opa         = n_reg;
      io.div_opb         = d;
   end
   // verdict registers stay untouched through DONE so the response is stable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_reg    <= '0;
         is_prime <= 1'b0;
         factor   <= '0;
      end else if (load) begin
         n_reg    <= io.req_num;
         is_prime <= 1'b0;
         factor   <= '0;
      end else if (state == ST_CHECK) begin
         is_prime <= n_reg == nbits'(2) || n_reg == nbits'(3);
      end else if (got_res) begin
         if (rem_zero) factor <= d;
         else if (sq_gt) is_prime <= 1'b1;
      end
   end
endmodule
